// File: rtl/multicycle_datapath.sv
// multicycle_datapath: four-state (FETCH/DECODE/EXEC/WB) 19-bit instruction core
// with an 8-entry register file, carry/zero flags, branches and a return stack.
// Optional build macro R0_ZERO_EN: register 0 reads as zero and ignores writes.
module multicycle_datapath #(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    input  logic [18:0]     imem_data,
    input  logic            imem_valid,
    output logic            flag_c,
    output logic            flag_z,
    output logic            halted,
    output logic            stack_err
);
    localparam int AW   = $clog2(STACK_DEPTH);
    localparam int SP_W = AW + 1;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t             r_state, w_state_next;
    logic [PC_W-1:0]    r_pc;
    logic [18:0]        r_ir;
    logic [DATA_W-1:0]  r_regs [8];
    logic               r_flag_c, r_flag_z, r_err;
    logic [SP_W-1:0]    r_sp;
    logic [PC_W-1:0]    r_stack [STACK_DEPTH];
    logic [PC_W-1:0]    r_ret_addr;
    logic [DATA_W-1:0]  r_op_a, r_op_b, r_alu_res;
    logic               r_alu_c;

    // Instruction field decode
    logic [1:0]        w_class, w_cond;
    logic [2:0]        w_op, w_rd, w_rs1, w_rs2;
    logic [PC_W-1:0]   w_target, w_pc_inc;
    logic [AW-1:0]     w_sp_top;
    assign w_class  = r_ir[18:17];
    assign w_op     = r_ir[16:14];
    assign w_cond   = r_ir[16:15];
    assign w_rd     = r_ir[13:11];
    assign w_rs1    = r_ir[10:8];
    assign w_rs2    = r_ir[7:5];
    assign w_target = r_ir[PC_W-1:0];
    assign w_pc_inc = r_pc + 1'b1;
    assign w_sp_top = r_sp[AW-1:0] - 1'b1;

    logic w_is_call, w_is_ret, w_is_halt, w_call_full, w_ret_empty, w_stop, w_taken;
    assign w_is_call   = (w_class == 2'b10) && (w_cond == 2'b11);
    assign w_is_ret    = (w_class == 2'b11) && !r_ir[16];
    assign w_is_halt   = (w_class == 2'b11) && r_ir[16];
    assign w_call_full = w_is_call && (r_sp == SP_W'(STACK_DEPTH));
    assign w_ret_empty = w_is_ret && (r_sp == '0);
    assign w_stop      = w_is_halt || w_call_full || w_ret_empty;

    // Conditional branch evaluation against the committed flags
    always_comb begin
        w_taken = 1'b0;
        case (w_cond)
            2'b00:   w_taken = 1'b1;
            2'b01:   w_taken = r_flag_z;
            2'b10:   w_taken = r_flag_c;
            default: w_taken = 1'b0;
        endcase
    end

    // Register file read ports, optionally hard-wiring r0 to zero
    logic [DATA_W-1:0] w_rs1_val, w_rs2_val;
    always_comb begin
        w_rs1_val = r_regs[w_rs1];
        w_rs2_val = r_regs[w_rs2];
`ifdef R0_ZERO_EN
        if (w_rs1 == 3'd0) w_rs1_val = '0;
        if (w_rs2 == 3'd0) w_rs2_val = '0;
`endif
    end

    // ALU on the operands latched in DECODE
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;
    always_comb begin
        w_sum     = (DATA_W+1)'(r_op_a) + (DATA_W+1)'(r_op_b)
                  + (DATA_W+1)'((w_op == 3'b001) ? r_flag_c : 1'b0);
        w_alu_res = w_sum[DATA_W-1:0];
        w_alu_c   = w_sum[DATA_W];
        case (w_op)
            3'b010: begin w_alu_res = r_op_a - r_op_b;    w_alu_c = (r_op_a < r_op_b); end
            3'b011: begin w_alu_res = r_op_a & r_op_b;    w_alu_c = 1'b0; end
            3'b100: begin w_alu_res = r_op_a | r_op_b;    w_alu_c = 1'b0; end
            3'b101: begin w_alu_res = r_op_a ^ r_op_b;    w_alu_c = 1'b0; end
            3'b110: begin w_alu_res = r_op_a << 1;        w_alu_c = r_op_a[DATA_W-1]; end
            3'b111: begin w_alu_res = r_op_a >> 1;        w_alu_c = r_op_a[0]; end
            default: ;
        endcase
    end

    // Register file write port (active in WB for ALU and load-immediate)
    logic              w_rf_we;
    logic [DATA_W-1:0] w_rf_wdata;
    always_comb begin
        w_rf_we    = (r_state == S_WB) && ((w_class == 2'b00) || (w_class == 2'b01));
`ifdef R0_ZERO_EN
        if (w_rd == 3'd0) w_rf_we = 1'b0;
`endif
        w_rf_wdata = (w_class == 2'b01) ? DATA_W'(r_ir[7:0]) : r_alu_res;
    end

    // Next-state logic; a fetch waits for valid data, errors and halt park in HALT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:  if (imem_valid) w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC:   w_state_next = S_WB;
            S_WB:     w_state_next = w_stop ? S_HALT : S_FETCH;
            default:  w_state_next = S_HALT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_next;
    end

    // Instruction register, captured when the fetch completes
    always_ff @(posedge clk) begin
        if (rst)                                  r_ir <= '0;
        else if (r_state == S_FETCH && imem_valid) r_ir <= imem_data;
    end

    // Datapath pipeline registers: operands in DECODE, ALU result and return address in EXEC
    always_ff @(posedge clk) begin
        if (r_state == S_DECODE) begin
            r_op_a <= w_rs1_val;
            r_op_b <= w_rs2_val;
        end
        if (r_state == S_EXEC) begin
            r_alu_res  <= w_alu_res;
            r_alu_c    <= w_alu_c;
            r_ret_addr <= r_stack[w_sp_top];
        end
    end

    // Return-stack storage, written by a non-overflowing call in WB
    always_ff @(posedge clk) begin
        if (r_state == S_WB && w_is_call && !w_call_full)
            r_stack[r_sp[AW-1:0]] <= w_pc_inc;
    end

    // Register file
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else if (w_rf_we) begin
            r_regs[w_rd] <= w_rf_wdata;
        end
    end

    // Architectural commit in WB: PC, flags, stack pointer, sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
            r_sp     <= '0;
            r_err    <= 1'b0;
        end else if (r_state == S_WB) begin
            r_pc <= w_pc_inc;
            case (w_class)
                2'b00: begin
                    r_flag_c <= r_alu_c;
                    r_flag_z <= (r_alu_res == '0);
                end
                2'b10: begin
                    if (w_is_call) begin
                        if (w_call_full) begin
                            r_err <= 1'b1;
                            r_pc  <= r_pc;
                        end else begin
                            r_sp <= r_sp + 1'b1;
                            r_pc <= w_target;
                        end
                    end else if (w_taken) begin
                        r_pc <= w_target;
                    end
                end
                2'b11: begin
                    if (w_is_ret) begin
                        if (w_ret_empty) begin
                            r_err <= 1'b1;
                            r_pc  <= r_pc;
                        end else begin
                            r_sp <= r_sp - 1'b1;
                            r_pc <= r_ret_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign imem_req  = (r_state == S_FETCH) && !rst;
    assign flag_c    = r_flag_c;
    assign flag_z    = r_flag_z;
    assign halted    = (r_state == S_HALT);
    assign stack_err = r_err;
endmodule
